// File: rtl/config_frame_loader_pkg.sv
// Shared constants and types for the configuration frame loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: sync pattern, default desync bit index, bytes per config word,
// loader state enum and a helper for the word-counter width.
package config_frame_loader_pkg;

    localparam logic [31:0] SYNC_WORD           = 32'hFAB0_FAB1;
    localparam int          DESYNC_FLAG_DEFAULT = 20;
    localparam int          BYTES_PER_WORD      = 4;
    localparam int          WORD_BITS           = 8 * BYTES_PER_WORD;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // Width of a counter that must hold values 0..num_words-1.
    function automatic int cnt_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage : config_frame_loader_pkg

// File: rtl/cfg_word_assembler.sv
// Packs bytes (MSB first) into 32-bit words.
// Latency: 0 cycles -- word_vld/word_dat are combinational on the 4th byte.
// Backpressure: none; every qualified byte is absorbed.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                discard any partial word (byte counter and holding reg)
//   byte_vld/byte_dat  incoming byte and its qualifier
//   word_vld/word_dat  one-cycle completed word, {3 held bytes, current byte}
module cfg_word_assembler
    import config_frame_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_dat,
    output logic                 word_vld,
    output logic [WORD_BITS-1:0] word_dat
);

    localparam int BCW = cnt_width(BYTES_PER_WORD);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

    logic [BCW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [WORD_BITS-9:0]     hold_q, hold_d;

    // The word is presented in the same cycle as its final byte so the
    // consumer can register it on the edge that samples that byte.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        hold_d     = hold_q;
        word_vld   = byte_vld && (byte_cnt_q == LAST_BYTE);
        word_dat   = {hold_q, byte_dat};

        if (clr) begin
            byte_cnt_d = '0;
            hold_d     = '0;
        end else if (byte_vld) begin
            hold_d     = {hold_q[WORD_BITS-17:0], byte_dat};
            // Wraps to zero after the last byte of a word.
            byte_cnt_d = byte_cnt_q + BCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule : cfg_word_assembler

// File: rtl/config_frame_loader.sv
// Bitstream byte loader: sync hunt, frame address load, frame data load, commit strobe.
// Latency: registers update on the edge sampling a word's 4th byte; strobe 1 cycle after last data byte.
// Backpressure: none; one byte per cycle accepted at full rate, bytes never dropped while synced.
//
// Ports:
//   CLK, resetn            clock, asynchronous active-low reset
//   byte_valid, byte_data  received byte stream
//   FrameAddressRegister   last accepted (non-desync) frame address word
//   FrameData              NumberOfRows+2 row words; first received word in the top slice
//   LongFrameStrobe        one-cycle frame commit pulse
//   active                 high while synced (not hunting)
module config_frame_loader
    import config_frame_loader_pkg::*;
#(
    parameter int          NumberOfRows    = 10,
    parameter int          FrameBitsPerRow = WORD_BITS,
    parameter int          desync_flag     = DESYNC_FLAG_DEFAULT,
    parameter logic [31:0] SyncWord        = SYNC_WORD
) (
    input  logic                                       CLK,
    input  logic                                       resetn,
    input  logic                                       byte_valid,
    input  logic [7:0]                                 byte_data,
    output logic [FrameBitsPerRow-1:0]                 FrameAddressRegister,
    output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0] FrameData,
    output logic                                       LongFrameStrobe,
    output logic                                       active
);

    localparam int NUM_WORDS = NumberOfRows + 2;
    localparam int WCW       = cnt_width(NUM_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

    state_e                                   state_q, state_d;
    // Only the three most recent bytes are kept; the fourth is the live input.
    logic [23:0]                              window_q, window_d;
    logic [WCW-1:0]                           word_cnt_q, word_cnt_d;
    logic [FrameBitsPerRow-1:0]               far_q, far_d;
    logic [NUM_WORDS-1:0][FrameBitsPerRow-1:0] frame_q, frame_d;
    logic                                     strobe_q, strobe_d;

    logic                                     asm_clr;
    logic                                     asm_byte_vld;
    logic                                     asm_word_vld;
    logic [WORD_BITS-1:0]                     asm_word;
    logic [31:0]                              window_shift;
    logic [WCW-1:0]                           slice_idx;

    // Bytes seen while hunting only feed the sync window, never the assembler,
    // so the first address byte after sync always starts a fresh word.
    assign asm_byte_vld = byte_valid && (state_q != HUNT);

    cfg_word_assembler u_word_asm (
        .clk      (CLK),
        .rst_n    (resetn),
        .clr      (asm_clr),
        .byte_vld (asm_byte_vld),
        .byte_dat (byte_data),
        .word_vld (asm_word_vld),
        .word_dat (asm_word)
    );

    assign window_shift = {window_q, byte_data};
    // Word k of the frame lands in slice NUM_WORDS-1-k.
    assign slice_idx    = LAST_WORD - word_cnt_q;

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        word_cnt_d = word_cnt_q;
        far_d      = far_q;
        frame_d    = frame_q;
        strobe_d   = 1'b0;
        asm_clr    = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (byte_valid) begin
                    window_d = window_shift[23:0];
                    if (window_shift == SyncWord) begin
                        state_d    = ADDR;
                        word_cnt_d = '0;
                        asm_clr    = 1'b1;
                    end
                end
            end

            ADDR: begin
                if (asm_word_vld) begin
                    if (asm_word[desync_flag]) begin
                        // Desync: address register deliberately left untouched.
                        state_d  = HUNT;
                        window_d = '0;
                        asm_clr  = 1'b1;
                    end else begin
                        far_d      = asm_word;
                        word_cnt_d = '0;
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (asm_word_vld) begin
                    frame_d[slice_idx] = asm_word;
                    if (word_cnt_q == LAST_WORD) begin
                        // Counter stays saturated; ADDR clears it before reuse.
                        state_d  = ADDR;
                        strobe_d = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= HUNT;
            window_q   <= '0;
            word_cnt_q <= '0;
            far_q      <= '0;
            frame_q    <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            word_cnt_q <= word_cnt_d;
            far_q      <= far_d;
            frame_q    <= frame_d;
            strobe_q   <= strobe_d;
        end
    end

    assign FrameAddressRegister = far_q;
    assign FrameData            = frame_q;
    assign LongFrameStrobe      = strobe_q;
    assign active               = (state_q != HUNT);

endmodule : config_frame_loader

// File: tb/tb_config_frame_loader.sv
// Self-checking bench for config_frame_loader.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_config_frame_loader;

    localparam int          NR   = 10;
    localparam int          NW   = NR + 2;
    localparam int          FB   = 32;
    localparam int          FW   = FB * NW;
    localparam int          DF   = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    typedef logic [31:0] word_arr_t [NW];

    logic          CLK = 1'b0;
    logic          resetn;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [FB-1:0] far;
    logic [FW-1:0] fd;
    logic          strobe;
    logic          active;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_byte_cyc = 0;
    int strobe_cycles[$];

    logic [FB-1:0] exp_far;
    logic [FW-1:0] exp_fd;

    config_frame_loader #(
        .NumberOfRows    (NR),
        .FrameBitsPerRow (FB),
        .desync_flag     (DF),
        .SyncWord        (SYNC)
    ) dut (
        .CLK                  (CLK),
        .resetn               (resetn),
        .byte_valid           (byte_valid),
        .byte_data            (byte_data),
        .FrameAddressRegister (far),
        .FrameData            (fd),
        .LongFrameStrobe      (strobe),
        .active               (active)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor: negedge index of every cycle where the strobe is high.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (strobe === 1'b1) strobe_cycles.push_back(cyc);
    end

    // Reference model: the whole frame as the spec lays it out,
    // slice j holds the word received in position NW-1-j.
    function automatic logic [FW-1:0] build_frame(input word_arr_t w);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < NW; k++) f[(NW-1-k)*FB +: FB] = w[k];
        return f;
    endfunction

    // All task entry/exit points sit 1 time unit after a rising edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge CLK);
        #1;
        byte_valid    = 1'b0;
        byte_data     = 8'($urandom);
        last_byte_cyc = cyc + 1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic gen_frame(output logic [31:0] addr, output word_arr_t w);
        addr = $urandom & ~(32'd1 << DF);
        for (int k = 0; k < NW; k++) w[k] = $urandom;
    endtask

    task automatic send_frame(input logic [31:0] addr, input word_arr_t w, input int gap);
        send_word(addr, gap);
        for (int k = 0; k < NW; k++) send_word(w[k], gap);
        exp_far = addr;
        exp_fd  = build_frame(w);
    endtask

    task automatic test_reset;
        resetn     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        checks++; if (far !== '0) begin errors++; $display("FAIL reset_far: got %h expected 0", far); end
        checks++; if (fd !== '0) begin errors++; $display("FAIL reset_fd: got %h expected 0", fd); end
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        exp_far = '0;
        exp_fd  = '0;
    endtask

    task automatic test_sync_detect;
        repeat ($urandom_range(2, 6)) send_byte(8'($urandom_range(0, 127)), 0);
        send_byte(8'h00, 0); send_byte(8'hFA, 0); send_byte(8'hB0, 0); send_byte(8'hFA, 0);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL sync_pre_active: got %b expected 0", active); end
        send_byte(8'hB1, 0);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL sync_active: got %b expected 1", active); end
        send_word(32'h0010_0000, 0);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL sync_desync_active: got %b expected 0", active); end
        checks++; if (far !== '0) begin errors++; $display("FAIL sync_desync_far: got %h expected 0", far); end
        send_byte(8'hFA, 0); send_byte(8'hB0, 0); send_byte(8'hFA, 0); send_byte(8'hB0, 0); send_byte(8'hFA, 0);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL sync_mis_pre_active: got %b expected 0", active); end
        send_byte(8'hB1, 0);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL sync_mis_active: got %b expected 1", active); end
        send_word(32'h0010_0000, 0);
    endtask

    task automatic test_full_frame;
        word_arr_t w;
        int exp_strobe;
        strobe_cycles.delete();
        for (int k = 0; k < NW; k++) w[k] = k;
        send_word(SYNC, 0);
        send_word(32'h8000_0001, 0);
        checks++; if (far !== 32'h8000_0001) begin errors++; $display("FAIL full_far_latency: got %h expected 80000001", far); end
        for (int k = 0; k < NW; k++) begin
            send_word(w[k], 0);
            if (k == 5) begin
                checks++;
                if (fd[(NW-1-5)*FB +: FB] !== 32'd5) begin
                    errors++; $display("FAIL full_slice_latency: got %h expected 5", fd[(NW-1-5)*FB +: FB]);
                end
            end
        end
        exp_strobe = last_byte_cyc;
        exp_far    = 32'h8000_0001;
        exp_fd     = build_frame(w);
        checks++; if (strobe !== 1'b1) begin errors++; $display("FAIL full_strobe_high: got %b expected 1", strobe); end
        idle(1);
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL full_strobe_low: got %b expected 0", strobe); end
        idle(2);
        checks++; if (far !== exp_far) begin errors++; $display("FAIL full_far: got %h expected %h", far, exp_far); end
        checks++; if (fd !== exp_fd) begin errors++; $display("FAIL full_fd: got %h expected %h", fd, exp_fd); end
        checks++; if (fd[(NW-1)*FB +: FB] !== 32'h0) begin errors++; $display("FAIL full_slice_top: got %h expected 0", fd[(NW-1)*FB +: FB]); end
        checks++; if (fd[FB-1:0] !== 32'hB) begin errors++; $display("FAIL full_slice0: got %h expected b", fd[FB-1:0]); end
        checks++;
        if (strobe_cycles.size() != 1 || strobe_cycles[0] != exp_strobe) begin
            errors++; $display("FAIL full_strobe_count: got %0d strobes expected 1 at cycle %0d", strobe_cycles.size(), exp_strobe);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1, a2;
        word_arr_t   w1, w2;
        logic [7:0]  bytes[$];
        int e1, e2;
        strobe_cycles.delete();
        gen_frame(a1, w1);
        gen_frame(a2, w2);
        for (int i = 3; i >= 0; i--) bytes.push_back(a1[8*i +: 8]);
        for (int k = 0; k < NW; k++) for (int i = 3; i >= 0; i--) bytes.push_back(w1[k][8*i +: 8]);
        for (int i = 3; i >= 0; i--) bytes.push_back(a2[8*i +: 8]);
        for (int k = 0; k < NW; k++) for (int i = 3; i >= 0; i--) bytes.push_back(w2[k][8*i +: 8]);
        e1 = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], 0);
            if (i == 4*(NW+1) - 1) begin
                e1 = last_byte_cyc;
                checks++;
                if (fd !== build_frame(w1)) begin errors++; $display("FAIL b2b_fd1: got %h expected %h", fd, build_frame(w1)); end
            end
        end
        e2 = last_byte_cyc;
        exp_far = a2;
        exp_fd  = build_frame(w2);
        idle(3);
        checks++;
        if (strobe_cycles.size() != 2) begin
            errors++; $display("FAIL b2b_strobe_count: got %0d expected 2", strobe_cycles.size());
        end else begin
            if (strobe_cycles[0] != e1 || strobe_cycles[1] != e2 || strobe_cycles[1] - strobe_cycles[0] != 4*(NW+1)) begin
                errors++; $display("FAIL b2b_strobe_timing: got %0d,%0d expected %0d,%0d", strobe_cycles[0], strobe_cycles[1], e1, e2);
            end
        end
        checks++; if (far !== exp_far) begin errors++; $display("FAIL b2b_far: got %h expected %h", far, exp_far); end
        checks++; if (fd !== exp_fd) begin errors++; $display("FAIL b2b_fd2: got %h expected %h", fd, exp_fd); end
    endtask

    task automatic test_desync;
        strobe_cycles.delete();
        send_word($urandom | (32'd1 << DF), 0);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL desync_active: got %b expected 0", active); end
        checks++; if (far !== exp_far) begin errors++; $display("FAIL desync_far: got %h expected %h", far, exp_far); end
        for (int i = 0; i < 4*NW; i++) send_byte(8'($urandom_range(0, 127)), $urandom_range(0, 1));
        idle(2);
        checks++; if (fd !== exp_fd) begin errors++; $display("FAIL desync_fd: got %h expected %h", fd, exp_fd); end
        checks++; if (far !== exp_far) begin errors++; $display("FAIL desync_far_after: got %h expected %h", far, exp_far); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL desync_active_after: got %b expected 0", active); end
        checks++; if (strobe_cycles.size() != 0) begin errors++; $display("FAIL desync_strobe: got %0d expected 0", strobe_cycles.size()); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] a;
        word_arr_t   w;
        int exp_strobe;
        strobe_cycles.delete();
        gen_frame(a, w);
        send_word(SYNC, 0);
        send_word(a, 0);
        for (int k = 0; k < 5; k++) send_word(w[k], 0);
        #2 resetn = 1'b0;
        #1;
        checks++; if (far !== '0) begin errors++; $display("FAIL rst_mid_far: got %h expected 0", far); end
        checks++; if (fd !== '0) begin errors++; $display("FAIL rst_mid_fd: got %h expected 0", fd); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %b expected 0", active); end
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        // Reset landing while the strobe is high must kill it.
        gen_frame(a, w);
        send_word(SYNC, 0);
        send_frame(a, w, 0);
        #1 resetn = 1'b0;
        #1;
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", strobe); end
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (strobe_cycles.size() != 0) begin errors++; $display("FAIL rst_strobe_count: got %0d expected 0", strobe_cycles.size()); end
        gen_frame(a, w);
        send_word(SYNC, 0);
        send_frame(a, w, 0);
        exp_strobe = last_byte_cyc;
        idle(2);
        checks++; if (far !== exp_far) begin errors++; $display("FAIL rst_reload_far: got %h expected %h", far, exp_far); end
        checks++; if (fd !== exp_fd) begin errors++; $display("FAIL rst_reload_fd: got %h expected %h", fd, exp_fd); end
        checks++;
        if (strobe_cycles.size() != 1 || strobe_cycles[0] != exp_strobe) begin
            errors++; $display("FAIL rst_reload_strobe: got %0d strobes expected 1 at cycle %0d", strobe_cycles.size(), exp_strobe);
        end
    endtask

    task automatic test_gapped;
        word_arr_t w;
        int exp_strobe;
        for (int k = 0; k < NW; k++) w[k] = k;
        send_word(32'h0010_0000, 6);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL gap_desync_active: got %b expected 0", active); end
        strobe_cycles.delete();
        send_word(SYNC, 6);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL gap_sync_active: got %b expected 1", active); end
        send_frame(32'h8000_0001, w, 6);
        exp_strobe = last_byte_cyc;
        idle(8);
        checks++; if (far !== 32'h8000_0001) begin errors++; $display("FAIL gap_far: got %h expected 80000001", far); end
        checks++; if (fd !== exp_fd) begin errors++; $display("FAIL gap_fd: got %h expected %h", fd, exp_fd); end
        checks++;
        if (strobe_cycles.size() != 1 || strobe_cycles[0] != exp_strobe) begin
            errors++; $display("FAIL gap_strobe: got %0d strobes expected 1 at cycle %0d", strobe_cycles.size(), exp_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_sync_detect();
        test_full_frame();
        test_back_to_back();
        test_desync();
        test_reset_mid_frame();
        test_gapped();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_config_frame_loader
